// File: rtl/shru_dcache_arbiter.sv
// Shares one dcache request port between the LSU and the shadow register unit (SHRU).
// Optional perf counters are built when SHRU_ARB_PERF_EN is defined.
module shru_dcache_arbiter #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [DATA_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,

    input  logic                    shru_req_i,
    input  logic                    shru_we_i,
    input  logic [DATA_WIDTH-1:0]   shru_addr_i,
    input  logic [DATA_WIDTH-1:0]   shru_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] shru_be_i,
    input  logic                    shru_lock_i,
    output logic                    shru_gnt_o,
    output logic                    shru_rvalid_o,
    output logic [DATA_WIDTH-1:0]   shru_rdata_o,

    output logic                    dc_req_o,
    output logic                    dc_we_o,
    output logic [DATA_WIDTH-1:0]   dc_addr_o,
    output logic [DATA_WIDTH-1:0]   dc_wdata_o,
    output logic [DATA_WIDTH/8-1:0] dc_be_o,
    input  logic                    dc_gnt_i,
    input  logic                    dc_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   dc_rdata_i,

    output logic                    lsu_hazard_o,
    output logic                    err_o,
    output logic [31:0]             perf_shru_gnt_o,
    output logic [31:0]             perf_lsu_gnt_o,
    output logic [31:0]             perf_lsu_stall_o
);

    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StHoldLsu, StHoldShru} state_e;

    state_e state_q, state_d;

    logic [MAX_OUTSTANDING-1:0]       fifo_vld_q, fifo_vld_d;
    logic [MAX_OUTSTANDING-1:0]       fifo_shru_q, fifo_shru_d;
    logic [MAX_OUTSTANDING-1:0]       fifo_we_q, fifo_we_d;
    logic [MAX_OUTSTANDING-1:0][11:0] fifo_off_q, fifo_off_d;
    logic [PtrW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                  starve_cnt_q, starve_cnt_d;
    logic                             err_q, err_d;

    logic fifo_full, fifo_empty, fifo_push, fifo_pop, head_shru;
    logic fifo_hit, presented_hit;
    logic sel_lsu, sel_shru, owner_req;
    logic [MAX_OUTSTANDING-1:0] ent_hit;

    // Valid entries are contiguous from rd_ptr, so one slot tells full/empty.
    assign fifo_full  = fifo_vld_q[wr_ptr_q];
    assign fifo_empty = ~fifo_vld_q[rd_ptr_q];
    assign head_shru  = fifo_shru_q[rd_ptr_q];
    assign fifo_push  = dc_req_o & dc_gnt_i;
    assign fifo_pop   = dc_rvalid_i & ~fifo_empty;

    for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_hit
        assign ent_hit[g] = fifo_vld_q[g] & fifo_shru_q[g] & fifo_we_q[g] &
                            (fifo_off_q[g] == lsu_addr_i[11:0]);
    end

    assign fifo_hit      = |ent_hit;
    assign presented_hit = shru_req_i & shru_we_i & (shru_addr_i[11:0] == lsu_addr_i[11:0]);
    assign lsu_hazard_o  = lsu_req_i & (fifo_hit | presented_hit);

    // Owner selection: a held owner is kept until its request is granted.
    always_comb begin
        sel_lsu  = 1'b0;
        sel_shru = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (shru_lock_i) begin
                    sel_shru = 1'b1;
                end else if (starve_cnt_q == StarveMax && lsu_req_i && !lsu_hazard_o) begin
                    sel_lsu = 1'b1;
                end else if (shru_req_i) begin
                    sel_shru = 1'b1;
                end else if (lsu_req_i && !lsu_hazard_o) begin
                    sel_lsu = 1'b1;
                end
            end
            StHoldLsu:  sel_lsu  = 1'b1;
            StHoldShru: sel_shru = 1'b1;
            default: ;
        endcase
        owner_req = (sel_shru & shru_req_i) | (sel_lsu & lsu_req_i);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (owner_req && !fifo_push) begin
                    state_d = sel_shru ? StHoldShru : StHoldLsu;
                end
            end
            StHoldLsu, StHoldShru: begin
                if (fifo_push || !owner_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dc_req_o   = owner_req & ~fifo_full;
        dc_we_o    = 1'b0;
        dc_addr_o  = '0;
        dc_wdata_o = '0;
        dc_be_o    = '0;
        if (dc_req_o) begin
            if (sel_shru) begin
                dc_we_o    = shru_we_i;
                dc_addr_o  = shru_addr_i;
                dc_wdata_o = shru_wdata_i;
                dc_be_o    = shru_be_i;
            end else begin
                dc_we_o    = lsu_we_i;
                dc_addr_o  = lsu_addr_i;
                dc_wdata_o = lsu_wdata_i;
                dc_be_o    = lsu_be_i;
            end
        end
        lsu_gnt_o     = dc_req_o & dc_gnt_i & sel_lsu;
        shru_gnt_o    = dc_req_o & dc_gnt_i & sel_shru;
        lsu_rvalid_o  = fifo_pop & ~head_shru;
        shru_rvalid_o = fifo_pop & head_shru;
        lsu_rdata_o   = lsu_rvalid_o ? dc_rdata_i : '0;
        shru_rdata_o  = shru_rvalid_o ? dc_rdata_i : '0;
        err_o         = err_q;
    end

    always_comb begin
        fifo_vld_d  = fifo_vld_q;
        fifo_shru_d = fifo_shru_q;
        fifo_we_d   = fifo_we_q;
        fifo_off_d  = fifo_off_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (fifo_push) begin
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            fifo_shru_d[wr_ptr_q] = sel_shru;
            fifo_we_d[wr_ptr_q]   = dc_we_o;
            fifo_off_d[wr_ptr_q]  = dc_addr_o[11:0];
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + 1'b1;
        end
        err_d = err_q | (dc_rvalid_i & fifo_empty);

        starve_cnt_d = starve_cnt_q;
        if (lsu_gnt_o) begin
            starve_cnt_d = '0;
        end else if (shru_lock_i || lsu_hazard_o) begin
            starve_cnt_d = starve_cnt_q;
        end else if (lsu_req_i && starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            fifo_vld_q   <= '0;
            fifo_shru_q  <= '0;
            fifo_we_q    <= '0;
            fifo_off_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_vld_q   <= fifo_vld_d;
            fifo_shru_q  <= fifo_shru_d;
            fifo_we_q    <= fifo_we_d;
            fifo_off_q   <= fifo_off_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

`ifdef SHRU_ARB_PERF_EN
    logic [31:0] perf_shru_q, perf_shru_d;
    logic [31:0] perf_lsu_q, perf_lsu_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_shru_d  = perf_shru_q + {31'd0, shru_gnt_o};
        perf_lsu_d   = perf_lsu_q + {31'd0, lsu_gnt_o};
        perf_stall_d = perf_stall_q + {31'd0, lsu_req_i & ~lsu_gnt_o};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_shru_q  <= '0;
            perf_lsu_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_shru_q  <= perf_shru_d;
            perf_lsu_q   <= perf_lsu_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_shru_gnt_o  = perf_shru_q;
    assign perf_lsu_gnt_o   = perf_lsu_q;
    assign perf_lsu_stall_o = perf_stall_q;
`else
    assign perf_shru_gnt_o  = '0;
    assign perf_lsu_gnt_o   = '0;
    assign perf_lsu_stall_o = '0;
`endif

endmodule

// File: tb/tb_shru_dcache_arbiter.sv
// Self-checking bench for shru_dcache_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_shru_dcache_arbiter;

    localparam int DW = 64;
    localparam int MO = 4;
    localparam int SL = 8;

    localparam logic [63:0] AL  = 64'h9000_0F10;
    localparam logic [63:0] AL2 = 64'h9000_0F18;
    localparam logic [63:0] AS  = 64'h8000_0F10;
    localparam logic [63:0] AS2 = 64'h8000_0F18;

    logic          clk, rst_n;
    logic          lsu_req, lsu_we, shru_req, shru_we, shru_lock;
    logic [DW-1:0] lsu_addr, lsu_wdata, shru_addr, shru_wdata, dc_rdata;
    logic [7:0]    lsu_be, shru_be;
    logic          dc_gnt, dc_rvalid;

    logic          lsu_gnt, lsu_rvalid, shru_gnt, shru_rvalid;
    logic [DW-1:0] lsu_rdata, shru_rdata, dc_addr, dc_wdata;
    logic          dc_req, dc_we, lsu_hazard, err;
    logic [7:0]    dc_be;
    logic [31:0]   perf_shru, perf_lsu, perf_stall;

    int checks;
    int passes;

    shru_dcache_arbiter #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO),
        .STARVE_LIMIT    (SL)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .lsu_req_i        (lsu_req),
        .lsu_we_i         (lsu_we),
        .lsu_addr_i       (lsu_addr),
        .lsu_wdata_i      (lsu_wdata),
        .lsu_be_i         (lsu_be),
        .lsu_gnt_o        (lsu_gnt),
        .lsu_rvalid_o     (lsu_rvalid),
        .lsu_rdata_o      (lsu_rdata),
        .shru_req_i       (shru_req),
        .shru_we_i        (shru_we),
        .shru_addr_i      (shru_addr),
        .shru_wdata_i     (shru_wdata),
        .shru_be_i        (shru_be),
        .shru_lock_i      (shru_lock),
        .shru_gnt_o       (shru_gnt),
        .shru_rvalid_o    (shru_rvalid),
        .shru_rdata_o     (shru_rdata),
        .dc_req_o         (dc_req),
        .dc_we_o          (dc_we),
        .dc_addr_o        (dc_addr),
        .dc_wdata_o       (dc_wdata),
        .dc_be_o          (dc_be),
        .dc_gnt_i         (dc_gnt),
        .dc_rvalid_i      (dc_rvalid),
        .dc_rdata_i       (dc_rdata),
        .lsu_hazard_o     (lsu_hazard),
        .err_o            (err),
        .perf_shru_gnt_o  (perf_shru),
        .perf_lsu_gnt_o   (perf_lsu),
        .perf_lsu_stall_o (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        shru;
        logic        we;
        logic [11:0] off;
    } ent_t;

    ent_t        mq[$];
    int          m_pend;   // 0 none, 1 LSU, 2 SHRU: requester shown but not yet granted
    int          m_cnt;
    logic        m_err;
    logic        m_lg;
    logic [31:0] m_pshru, m_plsu, m_pstall;

    task automatic model_reset();
        mq.delete();
        m_pend   = 0;
        m_cnt    = 0;
        m_err    = 1'b0;
        m_lg     = 1'b0;
        m_pshru  = '0;
        m_plsu   = '0;
        m_pstall = '0;
    endtask

    task automatic model_check_and_step();
        logic        full, haz, shown, dreq, lg, sg, pop, lrv, srv, empty;
        int          own;
        logic [63:0] eaddr, ewdata;
        logic        ewe;
        logic [7:0]  ebe;
        full  = (mq.size() == MO);
        empty = (mq.size() == 0);
        haz   = 1'b0;
        if (lsu_req) begin
            foreach (mq[i]) if (mq[i].shru && mq[i].we && mq[i].off == lsu_addr[11:0]) haz = 1'b1;
            if (shru_req && shru_we && shru_addr[11:0] == lsu_addr[11:0]) haz = 1'b1;
        end
        if (m_pend != 0)                          own = m_pend;
        else if (shru_lock)                       own = 2;
        else if (m_cnt == SL && lsu_req && !haz)  own = 1;
        else if (shru_req)                        own = 2;
        else if (lsu_req && !haz)                 own = 1;
        else                                      own = 0;
        shown = (own == 1) ? lsu_req : (own == 2) ? shru_req : 1'b0;
        dreq  = shown && !full;
        lg    = dreq && dc_gnt && own == 1;
        sg    = dreq && dc_gnt && own == 2;
        pop   = dc_rvalid && !empty;
        lrv   = pop && !mq[0].shru;
        srv   = pop && mq[0].shru;
        eaddr  = !dreq ? 64'h0 : (own == 2) ? shru_addr : lsu_addr;
        ewdata = !dreq ? 64'h0 : (own == 2) ? shru_wdata : lsu_wdata;
        ewe    = dreq && ((own == 2) ? shru_we : lsu_we);
        ebe    = !dreq ? 8'h0 : (own == 2) ? shru_be : lsu_be;

        chk1("rnd.dc_req", dc_req, dreq);
        chk64("rnd.dc_addr", dc_addr, eaddr);
        chk64("rnd.dc_wdata", dc_wdata, ewdata);
        chk1("rnd.dc_we", dc_we, ewe);
        chk64("rnd.dc_be", 64'(dc_be), 64'(ebe));
        chk1("rnd.lsu_gnt", lsu_gnt, lg);
        chk1("rnd.shru_gnt", shru_gnt, sg);
        chk1("rnd.lsu_rvalid", lsu_rvalid, lrv);
        chk1("rnd.shru_rvalid", shru_rvalid, srv);
        chk64("rnd.lsu_rdata", lsu_rdata, lrv ? dc_rdata : 64'h0);
        chk64("rnd.shru_rdata", shru_rdata, srv ? dc_rdata : 64'h0);
        chk1("rnd.hazard", lsu_hazard, haz);
        chk1("rnd.err", err, m_err);
`ifdef SHRU_ARB_PERF_EN
        chk64("rnd.perf_shru", 64'(perf_shru), 64'(m_pshru));
        chk64("rnd.perf_lsu", 64'(perf_lsu), 64'(m_plsu));
        chk64("rnd.perf_stall", 64'(perf_stall), 64'(m_pstall));
`else
        chk64("rnd.perf_shru", 64'(perf_shru), 64'h0);
        chk64("rnd.perf_lsu", 64'(perf_lsu), 64'h0);
        chk64("rnd.perf_stall", 64'(perf_stall), 64'h0);
`endif

        if (pop) void'(mq.pop_front());
        if (dc_rvalid && empty) m_err = 1'b1;
        if (dreq && dc_gnt) mq.push_back('{shru: (own == 2), we: ewe, off: eaddr[11:0]});
        m_pend = (shown && !(lg || sg)) ? own : 0;
        if (lg)                                m_cnt = 0;
        else if (shru_lock || haz)             m_cnt = m_cnt;
        else if (lsu_req && m_cnt < SL)        m_cnt = m_cnt + 1;
        m_pshru  = m_pshru + 32'(sg);
        m_plsu   = m_plsu + 32'(lg);
        m_pstall = m_pstall + 32'(lsu_req && !lg);
        m_lg     = lg;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
        shru_req = 1'b0; shru_we = 1'b0; shru_addr = '0; shru_wdata = '0; shru_be = '0;
        shru_lock = 1'b0; dc_gnt = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       a[11:0] = 12'hF10;
            1:       a[11:0] = 12'hF18;
            default: a[11:0] = 12'h010;
        endcase
        return a;
    endfunction

    task automatic rnd_drive();
        if (!(lsu_req && !m_lg)) begin
            lsu_req   = ($urandom_range(0, 99) < 45);
            lsu_we    = 1'($urandom);
            lsu_addr  = rnd_addr();
            lsu_wdata = {$urandom, $urandom};
            lsu_be    = 8'($urandom);
        end
        if (!(shru_req && !shru_gnt)) begin
            shru_req   = ($urandom_range(0, 99) < 45);
            shru_we    = 1'($urandom);
            shru_addr  = rnd_addr();
            shru_wdata = {$urandom, $urandom};
            shru_be    = 8'($urandom);
        end
        if ($urandom_range(0, 99) < 4) shru_lock = ~shru_lock;
        dc_gnt    = ($urandom_range(0, 99) < 70);
        dc_rvalid = (mq.size() > 0) && ($urandom_range(0, 99) < 40);
        dc_rdata  = {$urandom, $urandom};
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        lreq;
        logic [63:0] laddr;
        logic        sreq;
        logic        swe;
        logic [63:0] saddr;
        logic        gnt;
        logic        rv;
        logic [63:0] rdata;
        logic        e_dreq;
        logic [63:0] e_daddr;
        logic        e_lg;
        logic        e_sg;
        logic        e_lrv;
        logic        e_srv;
        logic        e_haz;
        logic        e_err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        checks = 0;
        passes = 0;

        tbl[0]  = '{0, 0,   0, 0, 0,   1, 0, 0,     0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, AL2, 0, 0, 0,   1, 0, 0,     1, AL2, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0,   1, 1, AS,  1, 1, 'h11,  1, AS,  0, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, AL,  0, 0, 0,   1, 0, 0,     0, 0,   0, 0, 0, 0, 1, 0};
        tbl[4]  = '{1, AL,  0, 0, 0,   1, 1, 'h22,  0, 0,   0, 0, 0, 1, 1, 0};
        tbl[5]  = '{1, AL,  0, 0, 0,   1, 0, 0,     1, AL,  1, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, AL2, 1, 1, AS2, 0, 0, 0,     1, AS2, 0, 0, 0, 0, 1, 0};
        tbl[7]  = '{1, AL2, 1, 1, AS2, 1, 0, 0,     1, AS2, 0, 1, 0, 0, 1, 0};
        tbl[8]  = '{1, AL2, 0, 0, 0,   0, 1, 'h33,  0, 0,   0, 0, 1, 0, 1, 0};
        tbl[9]  = '{1, AL2, 0, 0, 0,   0, 1, 'h44,  0, 0,   0, 0, 0, 1, 1, 0};
        tbl[10] = '{1, AL2, 0, 0, 0,   1, 0, 0,     1, AL2, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0,   0, 0, 0,   0, 1, 'h55,  0, 0,   0, 0, 1, 0, 0, 0};
        tbl[12] = '{0, 0,   0, 0, 0,   0, 1, 'h66,  0, 0,   0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0,   0, 0, 0,   0, 0, 0,     0, 0,   0, 0, 0, 0, 0, 1};

        // Reset state
        do_reset();
        #4;
        chk1("rst.dc_req", dc_req, 1'b0);
        chk64("rst.dc_addr", dc_addr, 64'h0);
        chk1("rst.lsu_gnt", lsu_gnt, 1'b0);
        chk1("rst.shru_gnt", shru_gnt, 1'b0);
        chk1("rst.lsu_rvalid", lsu_rvalid, 1'b0);
        chk1("rst.shru_rvalid", shru_rvalid, 1'b0);
        chk1("rst.hazard", lsu_hazard, 1'b0);
        chk1("rst.err", err, 1'b0);
        chk64("rst.perf_shru", 64'(perf_shru), 64'h0);
        chk64("rst.perf_lsu", 64'(perf_lsu), 64'h0);
        chk64("rst.perf_stall", 64'(perf_stall), 64'h0);
        tick();

        // Vector table, applied back-to-back from reset
        do_reset();
        for (int i = 0; i < 14; i++) begin
            lsu_req   = tbl[i].lreq;
            lsu_addr  = tbl[i].laddr;
            shru_req  = tbl[i].sreq;
            shru_we   = tbl[i].swe;
            shru_addr = tbl[i].saddr;
            dc_gnt    = tbl[i].gnt;
            dc_rvalid = tbl[i].rv;
            dc_rdata  = tbl[i].rdata;
            #4;
            chk1($sformatf("tbl%0d.dc_req", i), dc_req, tbl[i].e_dreq);
            chk64($sformatf("tbl%0d.dc_addr", i), dc_addr, tbl[i].e_daddr);
            chk1($sformatf("tbl%0d.lsu_gnt", i), lsu_gnt, tbl[i].e_lg);
            chk1($sformatf("tbl%0d.shru_gnt", i), shru_gnt, tbl[i].e_sg);
            chk1($sformatf("tbl%0d.lsu_rvalid", i), lsu_rvalid, tbl[i].e_lrv);
            chk1($sformatf("tbl%0d.shru_rvalid", i), shru_rvalid, tbl[i].e_srv);
            chk64($sformatf("tbl%0d.lsu_rdata", i), lsu_rdata,
                  tbl[i].e_lrv ? tbl[i].rdata : 64'h0);
            chk64($sformatf("tbl%0d.shru_rdata", i), shru_rdata,
                  tbl[i].e_srv ? tbl[i].rdata : 64'h0);
            chk1($sformatf("tbl%0d.hazard", i), lsu_hazard, tbl[i].e_haz);
            chk1($sformatf("tbl%0d.err", i), err, tbl[i].e_err);
            tick();
        end

        // Starvation override: SHRU wins 8 times, LSU on the 9th, responses two cycles later
        do_reset();
        shru_addr = 64'h8000_0100;
        lsu_addr  = 64'h9000_0200;
        for (int c = 1; c <= 14; c++) begin
            lsu_req   = (c <= 9);
            shru_req  = (c <= 12);
            dc_gnt    = 1'b1;
            dc_rvalid = (c >= 3);
            dc_rdata  = 64'hA000 + 64'(c);
            #4;
            chk1($sformatf("starve.c%0d.shru_gnt", c), shru_gnt, (c <= 12 && c != 9));
            chk1($sformatf("starve.c%0d.lsu_gnt", c), lsu_gnt, (c == 9));
            if (c >= 3) begin
                chk1($sformatf("starve.c%0d.lsu_rvalid", c), lsu_rvalid, (c == 11));
                chk1($sformatf("starve.c%0d.shru_rvalid", c), shru_rvalid, (c != 11));
                chk64($sformatf("starve.c%0d.rdata", c), (c == 11) ? lsu_rdata : shru_rdata,
                      64'hA000 + 64'(c));
            end
            tick();
        end

        // Lock blocks the LSU for 20 cycles even with the counter saturated
        do_reset();
        shru_addr = 64'h8000_0100;
        lsu_addr  = 64'h9000_0200;
        for (int c = 1; c <= 29; c++) begin
            shru_lock = (c >= 9 && c <= 28);
            lsu_req   = 1'b1;
            shru_req  = 1'b1;
            dc_gnt    = 1'b1;
            dc_rvalid = (c >= 2);
            #4;
            chk1($sformatf("lock.c%0d.lsu_gnt", c), lsu_gnt, (c == 29));
            chk1($sformatf("lock.c%0d.shru_gnt", c), shru_gnt, (c != 29));
            tick();
        end

        // Offset hazard against a pending SHRU store
        do_reset();
        shru_req = 1'b1; shru_we = 1'b1; shru_addr = AS; dc_gnt = 1'b1;
        #4;
        chk1("haz.s_gnt", shru_gnt, 1'b1);
        tick();
        shru_req = 1'b0; shru_we = 1'b0; lsu_req = 1'b1; lsu_addr = AL2;
        #4;
        chk1("haz.f18.hazard", lsu_hazard, 1'b0);
        chk1("haz.f18.gnt", lsu_gnt, 1'b1);
        tick();
        lsu_addr = AL;
        for (int c = 3; c <= 6; c++) begin
            dc_rvalid = (c == 6);
            #4;
            chk1($sformatf("haz.c%0d.hazard", c), lsu_hazard, 1'b1);
            chk1($sformatf("haz.c%0d.dc_req", c), dc_req, 1'b0);
            chk1($sformatf("haz.c%0d.lsu_gnt", c), lsu_gnt, 1'b0);
            tick();
        end
        #4;
        chk1("haz.c7.hazard", lsu_hazard, 1'b0);
        chk1("haz.c7.lsu_gnt", lsu_gnt, 1'b1);
        chk1("haz.c7.lsu_rvalid", lsu_rvalid, 1'b1);
        tick();
        lsu_req = 1'b0;
        #4;
        chk1("haz.c8.lsu_rvalid", lsu_rvalid, 1'b1);
        tick();

        // Held LSU request stays on the port while the dcache stalls
        do_reset();
        lsu_we = 1'b1; lsu_addr = 64'h9000_0040; lsu_wdata = 64'hDEAD; lsu_be = 8'hFF;
        shru_addr = 64'h8000_0080;
        for (int c = 1; c <= 6; c++) begin
            lsu_req  = 1'b1;
            shru_req = (c >= 2);
            dc_gnt   = (c == 6);
            #4;
            chk1($sformatf("hold.c%0d.dc_req", c), dc_req, 1'b1);
            chk64($sformatf("hold.c%0d.dc_addr", c), dc_addr, 64'h9000_0040);
            chk64($sformatf("hold.c%0d.dc_wdata", c), dc_wdata, 64'hDEAD);
            chk1($sformatf("hold.c%0d.dc_we", c), dc_we, 1'b1);
            chk1($sformatf("hold.c%0d.lsu_gnt", c), lsu_gnt, (c == 6));
            chk1($sformatf("hold.c%0d.shru_gnt", c), shru_gnt, 1'b0);
            tick();
        end
        lsu_req = 1'b0;
        #4;
        chk1("hold.c7.shru_gnt", shru_gnt, 1'b1);
        chk64("hold.c7.dc_addr", dc_addr, 64'h8000_0080);
        tick();

        // FIFO full: a same-cycle pop does not free a slot until the next cycle
        do_reset();
        shru_addr = 64'h8000_0100; shru_req = 1'b1; dc_gnt = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            dc_rvalid = (c == 6);
            #4;
            chk1($sformatf("full.c%0d.dc_req", c), dc_req, (c <= 4 || c == 7));
            chk1($sformatf("full.c%0d.shru_gnt", c), shru_gnt, (c <= 4 || c == 7));
            chk1($sformatf("full.c%0d.shru_rvalid", c), shru_rvalid, (c == 6));
            tick();
        end
        shru_req = 1'b0;

        // Responses after reset and with an empty FIFO are errors
        do_reset();
        lsu_req = 1'b1; lsu_addr = 64'h9000_0200; dc_gnt = 1'b1;
        #4;
        chk1("err.pre.lsu_gnt", lsu_gnt, 1'b1);
        tick();
        do_reset();
        dc_rvalid = 1'b1;
        #4;
        chk1("err.c1.lsu_rvalid", lsu_rvalid, 1'b0);
        chk1("err.c1.shru_rvalid", shru_rvalid, 1'b0);
        chk1("err.c1.err", err, 1'b0);
        tick();
        dc_rvalid = 1'b0;
        #4;
        chk1("err.c2.err", err, 1'b1);
        tick();
        dc_rvalid = 1'b1;
        #4;
        chk1("err.c3.lsu_rvalid", lsu_rvalid, 1'b0);
        chk1("err.c3.err", err, 1'b1);
        tick();
        dc_rvalid = 1'b0;
        #4;
        chk1("err.c4.err", err, 1'b1);
        tick();
        do_reset();
        #4;
        chk1("err.rst.err", err, 1'b0);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rnd_drive();
            #4;
            model_check_and_step();
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shru_dcache_arbiter.md
Name: shru_dcache_arbiter

Overview:
- Shares one data-cache request port between the load/store unit (LSU) and the shadow register unit (SHRU), which spills and restores shadow register frames.
- Sits between the EX-stage LSU, the shadow register controller and the dcache.
- Fixed SHRU priority with an LSU anti-starvation override, SHRU burst locking, and in-order response routing through an outstanding-request FIFO.
- Holds an LSU request while it hits the page offset of an in-flight SHRU store.

Parameters:
DATA_WIDTH, 64, data and address width (XLEN)
MAX_OUTSTANDING, 4, granted requests still waiting for a response; power of two, at least 2
STARVE_LIMIT, 8, consecutive cycles an LSU request is denied before it is forced to win

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lsu_req_i  in  1  LSU request valid
lsu_we_i  in  1  LSU store (1) or load (0)
lsu_addr_i  in  DATA_WIDTH  LSU address
lsu_wdata_i  in  DATA_WIDTH  LSU store data
lsu_be_i  in  DATA_WIDTH/8  LSU byte enables
lsu_gnt_o  out  1  LSU request accepted
lsu_rvalid_o  out  1  LSU response valid
lsu_rdata_o  out  DATA_WIDTH  LSU response data
shru_req_i, shru_we_i, shru_addr_i, shru_wdata_i, shru_be_i  in  as LSU  SHRU request fields
shru_lock_i  in  1  SHRU burst lock (frame spill or restore in progress)
shru_gnt_o, shru_rvalid_o, shru_rdata_o  out  as LSU  SHRU handshake and response
dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_be_o  out  as LSU  request to dcache
dc_gnt_i  in  1  dcache accepts request
dc_rvalid_i  in  1  dcache response, one per granted request, in order
dc_rdata_i  in  DATA_WIDTH  dcache response data
lsu_hazard_o  out  1  LSU request blocked by an offset hazard
err_o  out  1  sticky protocol error
perf_shru_gnt_o, perf_lsu_gnt_o, perf_lsu_stall_o  out  32  performance counters

Behaviour:
- Reset: FSM goes to IDLE. FIFO empty. Starvation counter 0. All outputs 0.
- FSM states: IDLE, HOLD_LSU, HOLD_SHRU. The owner's fields drive dc_* combinationally.
- IDLE selects an owner in this order:
  - (a) shru_lock_i=1 selects SHRU; the LSU is never chosen while lock is high.
  - (b) starvation counter equal to STARVE_LIMIT with lsu_req_i=1 and no hazard selects LSU.
  - (c) shru_req_i selects SHRU.
  - (d) lsu_req_i with no hazard selects LSU.
- If the selected owner's request is shown while dc_gnt_i=0, move to HOLD_x. HOLD_x keeps that owner until dc_gnt_i, then returns to IDLE. A request is never withdrawn or re-steered before it is granted.
- Requester grant: x_gnt_o = dc_gnt_i & owner==x. Grant latency is 0 cycles when the dcache grants in the same cycle.
- FIFO full: dc_req_o=0. This holds even if dc_rvalid_i pops an entry in the same cycle.
- FIFO push on dc_req_o & dc_gnt_i. Each entry stores {owner, we, addr[11:0]}.
- On dc_rvalid_i the FIFO pops the head. x_rvalid_o is driven for the head's owner in the same cycle, with rdata passed through.
- Simultaneous push and pop when not full: occupancy unchanged, pointers wrap modulo MAX_OUTSTANDING.
- Hazard: lsu_hazard_o = lsu_req_i & (any valid FIFO entry with owner=SHRU, we=1 and addr[11:0]==lsu_addr_i[11:0]). It also covers the SHRU store currently being presented. The LSU is not selected while the hazard is high.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle lsu_req_i=1 & lsu_gnt_o=0.
  - Clears on lsu_gnt_o.
  - Holds while shru_lock_i=1 or lsu_hazard_o=1.
- shru_lock_i dropping while HOLD_SHRU: the hold completes first.
- dc_rvalid_i with an empty FIFO: ignored, err_o set until reset.
- Reset mid-operation: FIFO contents discarded. Responses that arrive afterwards hit the error rule above.

Optional Feature:
- SHRU_ARB_PERF_EN defined:
  - perf_shru_gnt_o and perf_lsu_gnt_o count grants.
  - perf_lsu_stall_o counts cycles with lsu_req_i & ~lsu_gnt_o.
  - All three are 32-bit wrapping counters, reset to 0.
- Undefined: the three outputs are tied to 0 and no counter flops are built.

Test Plan:
- Both request, dc_gnt_i=1 every cycle, each response 2 cycles later -> SHRU granted 8 consecutive times, LSU granted on cycle 9, and responses routed to the correct owner in order.
- shru_lock_i=1 for 20 cycles with the LSU requesting -> lsu_gnt_o stays 0 and the counter stays at 8. After lock drops the LSU wins the first free cycle.
- SHRU store to 0x8000_0F10 granted and pending; LSU load 0x9000_0F10 -> lsu_hazard_o=1 until that response pops. LSU load 0x9000_0F18 -> no hazard.
- dc_gnt_i=0 for 5 cycles with the LSU presenting and SHRU arriving on cycle 2 -> FSM stays HOLD_LSU and LSU fields are stable until grant.
- 4 grants with no responses -> dc_req_o=0. A pop and a new request in the same cycle -> no grant that cycle, grant the next.
- dc_rvalid_i with an empty FIFO -> err_o=1 sticky, no rvalid to either requester. Assert rst_ni -> err_o=0.
